// File: rtl/br_write_ctrl.sv
// br_write_ctrl: zero-clears x1..xN after reset, then round-robin arbitrates two
// writeback requesters onto the single registered BR write port.
module br_write_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] br_a3,
  output logic [DATA_W-1:0] br_wd3,
  output logic              br_we3,
  output logic              init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, addr;
  logic [DATA_W-1:0] data;
  logic rr_ptr, last, g0, g1;
  // rr_ptr names the requester that wins when both are valid
  always_comb begin
    last = cnt == {ADDR_W{1'b1}};
    g0 = state == RUN && !rst && req0_valid && (!req1_valid || !rr_ptr);
    g1 = state == RUN && !rst && req1_valid && (!req0_valid || rr_ptr);
    addr = g1 ? req1_addr : req0_addr;
    data = g1 ? req1_data : req0_data;
    state_nx = (state == INIT && last) ? RUN : state;
  end
  assign req0_ready = g0;
  assign req1_ready = g1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? INIT : RUN;
      cnt <= {{(ADDR_W-1){1'b0}}, 1'b1};
      rr_ptr <= 1'b0;
      br_a3 <= '0;
      br_wd3 <= '0;
      br_we3 <= 1'b0;
      init_done <= !CLEAR_ON_RESET;
    end else begin
      state <= state_nx;
      if (state == INIT) begin
        br_a3 <= cnt;
        br_wd3 <= '0;
        br_we3 <= 1'b1;
        cnt <= cnt + 1'b1;
        init_done <= init_done | last;
      end else if (g0 || g1) begin
        br_a3 <= addr;
        br_wd3 <= data;
        br_we3 <= addr != '0;
        rr_ptr <= g0;
      end else begin
        br_we3 <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_br_write_ctrl.sv
// tb_br_write_ctrl: directed and randomized checks of br_write_ctrl against a queue-based model.
module tb_br_write_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [4:0] a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic r0, r1, we3, done;
  logic [4:0] a3;
  logic [31:0] wd3;
  logic nr0, nr1, nwe3, ndone;
  logic [4:0] na3;
  logic [31:0] nwd3;
  int checks = 0, passed = 0;
  logic p0, p1;

  always #5 clk = ~clk;

  br_write_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
    .br_a3(a3), .br_wd3(wd3), .br_we3(we3), .init_done(done)
  );

  br_write_ctrl #(.CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(nr0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(nr1),
    .br_a3(na3), .br_wd3(nwd3), .br_we3(nwe3), .init_done(ndone)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Model: pending clear writes as a queue, then plain arbitration rules.
  int clrq[$];
  bit started = 0, run = 0, rr = 0;
  logic [4:0] m_a3;
  logic [31:0] m_wd3;
  logic m_we3, m_done;

  always @(negedge clk) begin
    int w;
    w = -1;
    if (run && !rst && (v0 || v1)) w = (v0 && v1) ? int'(rr) : (v1 ? 1 : 0);
    if (started) begin
      chk("m_ready0", r0, w == 0);
      chk("m_ready1", r1, w == 1);
      chk("m_we3", we3, m_we3);
      chk("m_a3", a3, m_a3);
      chk("m_wd3", wd3, m_wd3);
      chk("m_init_done", done, m_done);
    end
    if (rst) begin
      started = 1;
      clrq.delete();
      for (int k = 1; k < 32; k++) clrq.push_back(k);
      run = 0; rr = 0;
      m_a3 = '0; m_wd3 = '0; m_we3 = 0; m_done = 0;
    end else if (!run) begin
      m_a3 = 5'(clrq.pop_front());
      m_wd3 = '0;
      m_we3 = 1;
      if (clrq.size() == 0) begin run = 1; m_done = 1; end
    end else if (w >= 0) begin
      m_a3 = w ? a1 : a0;
      m_wd3 = w ? d1 : d0;
      m_we3 = m_a3 != 0;
      rr = (w == 0);
    end else begin
      m_we3 = 0;
    end
  end

  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  initial begin
    v0 = 1; a0 = 5'd2; d0 = 32'hDEADBEEF;
    go;
    go; rst = 0;
    sample;
    chk("nc_init_done", ndone, 1);
    chk("nc_ready0", nr0, 1);
    chk("nc_we3", nwe3, 0);
    for (int i = 1; i < 10; i++) begin
      go; sample;
      chk("init_a3", a3, i);
      chk("init_ready0", r0, 0);
    end
    go; rst = 1;
    sample;
    chk("pre_rst_a3", a3, 10);
    chk("rst_ready0", r0, 0);
    go; rst = 0;
    sample;
    chk("rst_we3", we3, 0);
    chk("rst_a3", a3, 0);
    chk("rst_done", done, 0);
    for (int i = 1; i < 32; i++) begin
      go; sample;
      chk("clr_a3", a3, i);
      chk("clr_wd3", wd3, 0);
      chk("clr_we3", we3, 1);
      chk("clr_done", done, i == 31);
      chk("clr_ready0", r0, i == 31);
    end
    go; v0 = 0;
    sample;
    chk("w2_a3", a3, 2);
    chk("w2_wd3", wd3, 32'hDEADBEEF);
    chk("w2_we3", we3, 1);
    go; v1 = 1; a1 = 5'd0; d1 = 32'hFFFFFFFF;
    sample;
    chk("hold_we3", we3, 0);
    chk("hold_a3", a3, 2);
    chk("hold_wd3", wd3, 32'hDEADBEEF);
    chk("x0_ready1", r1, 1);
    go; v0 = 1; a0 = 5'd3; d0 = 32'h11; a1 = 5'd4; d1 = 32'h22;
    sample;
    chk("x0_we3", we3, 0);
    chk("both_ready0", r0, 1);
    chk("both_ready1", r1, 0);
    for (int k = 0; k < 4; k++) begin
      go; sample;
      chk("rr_a3", a3, (k % 2) ? 4 : 3);
      chk("rr_wd3", wd3, (k % 2) ? 32'h22 : 32'h11);
      chk("rr_ready0", r0, k % 2);
      chk("rr_ready1", r1, !(k % 2));
    end
    p0 = r0; p1 = r1;
    for (int n = 0; n < 3000; n++) begin
      go;
      rst = $urandom_range(0, 399) == 0;
      if (!v0 || p0) begin
        v0 = $urandom_range(0, 2) != 0;
        a0 = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
        d0 = $urandom;
      end
      if (!v1 || p1) begin
        v1 = $urandom_range(0, 2) != 0;
        a1 = $urandom_range(0, 3) == 0 ? a0 : 5'($urandom_range(0, 31));
        d1 = $urandom;
      end
      sample;
      p0 = r0; p1 = r1;
    end
    go;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/br_write_ctrl.md
Name: br_write_ctrl

Overview:
- Owns the single write port (a3/wd3/we3) of the BR register file.
- After reset it runs a clear sequence that writes zero to x1..x(2^ADDR_W-1).
- It then round-robin arbitrates between two writeback requesters (req0 = ALU writeback, req1 = load/memory writeback) using a valid/ready handshake.
- BR read ports are not touched by this block.

Parameters:
- ADDR_W, 5, register address width; the register file holds 2^ADDR_W registers.
- DATA_W, 32, write data width.
- CLEAR_ON_RESET, 1, 1 = run the zero-clear sequence after reset; 0 = enter RUN directly.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  ADDR_W  requester 1 destination register.
- req1_data  in  DATA_W  requester 1 write data.
- req1_ready  out  1  requester 1 write accepted this cycle.
- br_a3  out  ADDR_W  to BR a3, registered.
- br_wd3  out  DATA_W  to BR wd3, registered.
- br_we3  out  1  to BR we3, registered.
- init_done  out  1  high once the clear sequence is complete; stays high until the next rst.

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - state=INIT (or RUN if CLEAR_ON_RESET=0); cnt=1; rr_ptr=0.
  - br_a3=0, br_wd3=0, br_we3=0.
  - init_done=0 (or 1 if CLEAR_ON_RESET=0).
  - req*_ready=0 throughout reset.
- INIT: at each edge with rst=0:
  - br_a3<=cnt, br_wd3<=0, br_we3<=1, cnt<=cnt+1.
  - When cnt==2^ADDR_W-1: state<=RUN, init_done<=1.
  - Result is 2^ADDR_W-1 consecutive cycles showing br_we3=1 with br_a3=1..31; x0 is never written.
  - req*_ready=0 for the whole of INIT; requests are held off, not dropped.
- RUN ready rules (combinational from valid and rr_ptr):
  - Only one valid: that requester's ready=1.
  - Both valid: the requester indexed by rr_ptr gets ready=1; the other gets 0.
  - Neither valid: both ready=0.
  - At most one ready is high in any cycle.
- Handshake: a transfer occurs at an edge where valid&&ready. At that edge:
  - br_a3<=addr, br_wd3<=data, br_we3<=(addr!=0).
  - rr_ptr<=~granted_index.
- Latency: accept at edge N; br_we3 is high during cycle N..N+1; BR commits at edge N+1. Throughput is 1 write/cycle.
- No transfer at an edge: br_we3<=0; br_a3 and br_wd3 hold their previous values.
- Write to x0: the handshake completes (ready=1) but br_we3 stays 0; the write is silently discarded.
- Requesters must hold valid/addr/data stable until ready; the arbiter does not buffer.
- Same address from both requesters in consecutive cycles: both writes issue in grant order, and the later write wins in BR.
- rr_ptr does not change on a single-requester grant to the same index it already points away from. The rule rr_ptr<=~granted applies uniformly.
- rst during INIT or RUN: immediate return to the reset state. The in-flight br_we3 is cleared at that edge; the clear restarts from x1; unaccepted requests must be re-presented.
- cnt wraps only via reset; it is not used in RUN.

Test Plan:
- Reset then idle, CLEAR_ON_RESET=1 -> br_we3=1 for exactly 31 cycles with br_a3=1,2,...,31 and br_wd3=0; init_done rises at the edge that loads br_a3=31; req0_ready=0 throughout even with req0_valid=1.
- RUN, req0 only: addr=2, data=32'hDEADBEEF -> req0_ready=1 same cycle; next cycle br_a3=2, br_wd3=DEADBEEF, br_we3=1; following cycle br_we3=0 with br_a3/wd3 held.
- Both valid continuously, req0 addr=3 data=0x11, req1 addr=4 data=0x22, rr_ptr=0 -> grants alternate req0, req1, req0, ...; br_a3 sequence 3, 4, 3, 4; never both ready.
- req1 writes addr=0 data=0xFFFFFFFF -> req1_ready=1; br_we3 stays 0 the next cycle.
- rst=1 pulsed for one cycle mid-INIT (after br_a3=10) -> br_we3=0 that cycle; sequence restarts at br_a3=1; init_done stays 0 until br_a3=31.
- CLEAR_ON_RESET=0 -> init_done=1 and req0_ready=1 in the first cycle after rst deasserts; no clear writes occur.
